// File: rtl/not_response_checker.sv
// Output-side monitor for the NOT-gate harness: aligns the DUT response with the
// inverted stimulus by a fixed latency, counts vectors/mismatches, reports a verdict.
module not_response_checker #(
   parameter int unsigned WIDTH       = 2,
   parameter int unsigned LAT         = 0,
   parameter int unsigned NUM_VECTORS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stim_valid,
   input  logic [WIDTH-1:0] stim_a,
   input  logic [WIDTH-1:0] dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       vec_count,
   output logic [7:0]       err_count,
   output logic [7:0]       first_err_idx,
   output logic [WIDTH-1:0] first_err_got
);
   localparam int unsigned   CW       = 8;
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CW-1:0]    vec_nxt;
   logic [CW-1:0]    err_nxt;
   logic [CW-1:0]    fidx_nxt;
   logic [WIDTH-1:0] fgot_nxt;

   logic             in_run;
   logic             in_check;
   logic             accept;
   logic             clr_run;
   logic             cmp_vld;
   logic [WIDTH-1:0] cmp_exp;
   logic [CW-1:0]    cmp_idx;
   logic             pipe_busy;
   logic             mismatch;

   assign in_run   = (state == S_RUN);
   assign in_check = in_run || (state == S_DRAIN);
   assign accept   = in_run && stim_valid;
   assign clr_run  = start && ((state == S_IDLE) || (state == S_DONE));

   // Expected-value delay line; LAT=0 compares the live stimulus directly.
   generate
      if (LAT == 0) begin : g_direct
         assign cmp_vld   = accept;
         assign cmp_exp   = ~stim_a;
         assign cmp_idx   = vec_count;
         assign pipe_busy = 1'b0;
      end else begin : g_pipe
         logic [LAT-1:0]   vld_q;
         logic [WIDTH-1:0] exp_q [LAT];
         logic [CW-1:0]    idx_q [LAT];

         always_ff @(posedge clk) begin
            if (rst || clr_run) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= accept;
               for (int i = 1; i < int'(LAT); i++) begin
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            exp_q[0] <= ~stim_a;
            idx_q[0] <= vec_count;
            for (int i = 1; i < int'(LAT); i++) begin
               exp_q[i] <= exp_q[i-1];
               idx_q[i] <= idx_q[i-1];
            end
         end

         assign cmp_vld   = vld_q[LAT-1];
         assign cmp_exp   = exp_q[LAT-1];
         assign cmp_idx   = idx_q[LAT-1];
         assign pipe_busy = |vld_q;
      end
   endgenerate

   assign mismatch = in_check && cmp_vld && (dut_y != cmp_exp);

   // Next-state and next-result computation.
   always_comb begin
      state_nxt = state;
      vec_nxt   = vec_count;
      err_nxt   = err_count;
      fidx_nxt  = first_err_idx;
      fgot_nxt  = first_err_got;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_RUN;
               vec_nxt   = '0;
               err_nxt   = '0;
               fidx_nxt  = CNT_MAX;
               fgot_nxt  = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               vec_nxt = CW'(vec_count + 8'd1);
               if (vec_count == LAST_IDX) begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!pipe_busy) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Mismatches only occur in RUN/DRAIN, so they never collide with a clear.
      if (mismatch) begin
         if (err_count != CNT_MAX) begin
            err_nxt = CW'(err_count + 8'd1);
         end
         if (err_count == '0) begin
            fidx_nxt = cmp_idx;
            fgot_nxt = dut_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         vec_count     <= '0;
         err_count     <= '0;
         first_err_idx <= CNT_MAX;
         first_err_got <= '0;
      end else begin
         state         <= state_nxt;
         busy          <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
         done          <= (state_nxt == S_DONE);
         pass          <= (state_nxt == S_DONE) && (err_nxt == '0);
         vec_count     <= vec_nxt;
         err_count     <= err_nxt;
         first_err_idx <= fidx_nxt;
         first_err_got <= fgot_nxt;
      end
   end

endmodule

// File: tb/tb_not_response_checker.sv
// Bench for not_response_checker: three instances (LAT 0/1/2) share one stimulus
// stream, each fed by its own NOT-gate harness with optional fault injection.
module tb_not_response_checker;
   localparam int W  = 2;
   localparam int NV = 10;
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
   localparam int FM_GOOD = 0, FM_STUCK = 1, FM_FORCE = 2, FM_FLIP = 3;

   logic         clk = 1'b0;
   logic         rst, start, stim_valid;
   logic [W-1:0] stim_a;
   logic [W-1:0] dut_y [3];
   logic         busy_o [3];
   logic         done_o [3];
   logic         pass_o [3];
   logic [7:0]   vec_o  [3];
   logic [7:0]   err_o  [3];
   logic [7:0]   fidx_o [3];
   logic [W-1:0] fgot_o [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      not_response_checker #(.WIDTH(W), .LAT(g), .NUM_VECTORS(NV)) u_dut (
         .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid),
         .stim_a(stim_a), .dut_y(dut_y[g]),
         .busy(busy_o[g]), .done(done_o[g]), .pass(pass_o[g]),
         .vec_count(vec_o[g]), .err_count(err_o[g]),
         .first_err_idx(fidx_o[g]), .first_err_got(fgot_o[g])
      );
   end

   // NOT-gate harness with per-instance fault modes and LAT-cycle output delay.
   int           fm [3];
   int           fi [3];
   logic [W-1:0] fv [3];
   logic [W-1:0] flip [3];
   int           drv_idx;
   logic [W-1:0] resp [3];
   logic [W-1:0] d1_1, d1_2, d2_2;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         resp[k] = ~stim_a;
         if (fm[k] == FM_FORCE && stim_valid && drv_idx == fi[k]) resp[k] = fv[k];
         if (fm[k] == FM_FLIP) resp[k] = resp[k] ^ flip[k];
      end
   end

   always @(posedge clk) begin
      d1_1 <= resp[1];
      d1_2 <= resp[2];
      d2_2 <= d1_2;
   end

   always_comb begin
      dut_y[0] = resp[0];
      dut_y[1] = d1_1;
      dut_y[2] = d2_2;
      for (int k = 0; k < 3; k++) if (fm[k] == FM_STUCK) dut_y[k] = '0;
   end

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Behavioural model: run phase, counters and a timestamped list of due compares.
   typedef struct { int k; int due; int exp; int idx; } pend_t;
   pend_t pend[$];
   int    m_phase [3];
   int    m_vec   [3];
   int    m_err   [3];
   int    m_fidx  [3];
   int    m_fgot  [3];
   int    m_end   [3];
   bit    live = 1'b0;
   int    t = 0;

   task automatic model_step();
      pend_t keep[$];
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_phase[k] = P_IDLE; m_vec[k] = 0; m_err[k] = 0; m_fidx[k] = 255; m_fgot[k] = 0;
         end
         pend.delete();
         live = 1'b1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if ((m_phase[k] == P_IDLE || m_phase[k] == P_DONE) && start) begin
               m_phase[k] = P_RUN; m_vec[k] = 0; m_err[k] = 0; m_fidx[k] = 255; m_fgot[k] = 0;
            end else if (m_phase[k] == P_RUN && stim_valid) begin
               pend.push_back('{k, t + k, (~int'(stim_a)) & ((1 << W) - 1), m_vec[k]});
               m_vec[k]++;
               if (m_vec[k] == NV) begin
                  m_phase[k] = P_DRAIN;
                  m_end[k]   = t + k + 1;
               end
            end else if (m_phase[k] == P_DRAIN && t == m_end[k]) begin
               m_phase[k] = P_DONE;
            end
         end
         foreach (pend[i]) begin
            if (pend[i].due == t) begin
               int got;
               int kk;
               kk  = pend[i].k;
               got = int'(dut_y[kk]);
               if (got != pend[i].exp) begin
                  if (m_err[kk] == 0) begin
                     m_fidx[kk] = pend[i].idx;
                     m_fgot[kk] = got;
                  end
                  if (m_err[kk] < 255) m_err[kk]++;
               end
            end else begin
               keep.push_back(pend[i]);
            end
         end
         pend = keep;
      end
   endtask

   // Compare DUT outputs (state after the previous edge) then advance the model.
   always @(negedge clk) begin
      if (live) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), int'(busy_o[k]),
                (m_phase[k] == P_RUN || m_phase[k] == P_DRAIN) ? 1 : 0);
            chk($sformatf("done[%0d]", k), int'(done_o[k]), (m_phase[k] == P_DONE) ? 1 : 0);
            chk($sformatf("pass[%0d]", k), int'(pass_o[k]),
                (m_phase[k] == P_DONE && m_err[k] == 0) ? 1 : 0);
            chk($sformatf("vec_count[%0d]", k), int'(vec_o[k]), m_vec[k]);
            chk($sformatf("err_count[%0d]", k), int'(err_o[k]), m_err[k]);
            chk($sformatf("first_err_idx[%0d]", k), int'(fidx_o[k]), m_fidx[k]);
            chk($sformatf("first_err_got[%0d]", k), int'(fgot_o[k]), m_fgot[k]);
         end
      end
      model_step();
      t++;
   end

   int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_flip();
      for (int k = 0; k < 3; k++) flip[k] = ($urandom_range(3, 0) == 0) ? W'($urandom) : '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input bit use_seq, input int gap_max, input int first, input int last,
                        input bit glitch);
      for (int i = first; i < last; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (g) begin
            stim_valid = 1'b0;
            stim_a     = W'($urandom);
            start      = glitch && ($urandom_range(7, 0) == 0);
            rand_flip();
            tick();
         end
         stim_valid = 1'b1;
         stim_a     = use_seq ? W'(seq[i]) : W'($urandom);
         drv_idx    = i;
         start      = glitch && ($urandom_range(7, 0) == 0);
         rand_flip();
         tick();
      end
      stim_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic wait_done_all();
      int n;
      n = 0;
      while (!(done_o[0] && done_o[1] && done_o[2]) && n < 60) begin
         tick();
         n++;
      end
      chk("done_reached", int'(done_o[0] && done_o[1] && done_o[2]), 1);
   endtask

   initial begin
      int c_first;
      int n;
      rst = 1'b1; start = 1'b0; stim_valid = 1'b0; stim_a = '0; drv_idx = 0;
      for (int k = 0; k < 3; k++) begin
         fm[k] = FM_GOOD; fi[k] = 0; fv[k] = '0; flip[k] = '0;
      end
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_busy", int'(busy_o[0]), 0);
      chk("reset_done", int'(done_o[2]), 0);
      chk("reset_vec", int'(vec_o[1]), 0);
      chk("reset_fidx", int'(fidx_o[0]), 255);

      // Correct NOT, directed sequence, continuous valid.
      pulse_start();
      c_first = cyc;
      drive(1'b1, 0, 0, NV, 1'b0);
      n = 0;
      while (!done_o[2] && n < 40) begin
         tick();
         n++;
      end
      chk("lat2_done_latency", cyc - c_first, 13);
      wait_done_all();
      chk("s1_pass0", int'(pass_o[0]), 1);
      chk("s1_err0", int'(err_o[0]), 0);
      chk("s1_vec0", int'(vec_o[0]), 10);
      chk("s1_pass2", int'(pass_o[2]), 1);

      // Forced error at index 7 (LAT 0), stuck-at-0 (LAT 1); restarted from DONE.
      fm[0] = FM_FORCE; fi[0] = 7; fv[0] = 2'd2;
      fm[1] = FM_STUCK;
      pulse_start();
      drive(1'b1, 0, 0, NV, 1'b0);
      wait_done_all();
      chk("s2_err0", int'(err_o[0]), 1);
      chk("s2_fidx0", int'(fidx_o[0]), 7);
      chk("s2_fgot0", int'(fgot_o[0]), 2);
      chk("s2_pass0", int'(pass_o[0]), 0);
      chk("s2_err1", int'(err_o[1]), 9);
      chk("s2_fidx1", int'(fidx_o[1]), 0);
      chk("s2_fgot1", int'(fgot_o[1]), 0);
      chk("s2_pass2", int'(pass_o[2]), 1);

      // Reset after 4 vectors (with start held high), then a clean gapped run.
      fm[0] = FM_GOOD; fm[1] = FM_GOOD;
      pulse_start();
      drive(1'b1, 0, 0, 4, 1'b0);
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("s3_rst_vec", int'(vec_o[2]), 0);
      chk("s3_rst_busy", int'(busy_o[0]), 0);
      chk("s3_rst_fidx", int'(fidx_o[1]), 255);
      pulse_start();
      drive(1'b1, 2, 0, NV, 1'b0);
      wait_done_all();
      chk("s3_vec0", int'(vec_o[0]), 10);
      chk("s3_pass1", int'(pass_o[1]), 1);

      // start during RUN is ignored; stim_valid during DONE is ignored.
      pulse_start();
      drive(1'b1, 0, 0, 3, 1'b0);
      start = 1'b1; stim_valid = 1'b1; stim_a = W'(seq[3]); drv_idx = 3;
      tick();
      start = 1'b0; stim_valid = 1'b0;
      chk("s4_busy", int'(busy_o[0]), 1);
      chk("s4_vec", int'(vec_o[0]), 4);
      drive(1'b1, 0, 4, NV, 1'b0);
      wait_done_all();
      stim_valid = 1'b1;
      repeat (3) begin
         stim_a = W'($urandom);
         tick();
      end
      stim_valid = 1'b0;
      chk("s4_done_vec", int'(vec_o[0]), 10);
      chk("s4_done_hold", int'(done_o[0]), 1);

      // Randomized runs: fault modes, gaps, start glitches, occasional aborts.
      for (int r = 0; r < 14; r++) begin
         for (int k = 0; k < 3; k++) begin
            fm[k] = int'($urandom_range(3, 0));
            fi[k] = int'($urandom_range(NV - 1, 0));
            fv[k] = W'($urandom);
         end
         stim_valid = $urandom_range(1, 0) == 1;
         stim_a     = W'($urandom);
         pulse_start();
         if ($urandom_range(3, 0) == 0) begin
            drive(1'b0, 2, 0, int'($urandom_range(NV - 1, 1)), 1'b1);
            rst   = 1'b1;
            start = $urandom_range(1, 0) == 1;
            tick();
            rst = 1'b0; start = 1'b0;
            chk("abort_vec", int'(vec_o[0]), 0);
         end else begin
            drive(1'b0, 2, 0, NV, 1'b1);
            wait_done_all();
            repeat (int'($urandom_range(3, 0))) begin
               stim_valid = $urandom_range(1, 0) == 1;
               stim_a     = W'($urandom);
               tick();
            end
            stim_valid = 1'b0;
         end
      end

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/not_response_checker.md
# not_response_checker

Synthesizable self-checking monitor sitting at the output end of the NOT-gate test harness: where the stimulus side drives `A` into the `NOT` instance, this block samples the DUT output `Y`, compares it against the expected bitwise inverse of the applied stimulus, and reports pass/fail. The comparison is aligned by a configurable response latency. It counts vectors and mismatches, records the first failure, and presents a final verdict. It runs in simulation and on an FPGA bring-up board alike.

## Interface
- `WIDTH`, 2, bit width of stimulus and DUT response
- `LAT`, 0, DUT response latency in clock cycles, legal range 0..4
- `NUM_VECTORS`, 10, vectors to accept per run, legal range 1..255

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a run
- `stim_valid`  in  1  `stim_a` carries a vector this cycle
- `stim_a`  in  WIDTH  stimulus applied to the DUT this cycle
- `dut_y`  in  WIDTH  DUT output
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE
- `pass`  out  1  `done` and `err_count`==0
- `vec_count`  out  8  vectors accepted this run
- `err_count`  out  8  mismatches this run, saturating
- `first_err_idx`  out  8  0-based index of the first mismatching vector
- `first_err_got`  out  WIDTH  `dut_y` value at the first mismatch

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values: state IDLE; `busy`, `done`, `pass` at 0; all counters at 0; `first_err_idx` at 0xFF; `first_err_got` at 0; pipeline valid bits at 0.
- IDLE: `start` moves the block to RUN and clears the counters, `first_err_*`, and the pipeline.
- RUN: each cycle with `stim_valid`=1 accepts a vector. That increments `vec_count` and pushes {1, ~stim_a, vec_index} into a LAT-deep delay line.
- When the accepted vector makes `vec_count` equal NUM_VECTORS, the state moves to DRAIN in the same edge. `stim_valid` outside RUN is ignored.
- DRAIN: the block waits until the delay line holds no valid entries, then moves to DONE. With LAT=0, DRAIN lasts exactly 1 cycle.
- DONE: holds all results. `start` re-enters RUN with everything cleared. `start` in RUN or DRAIN is ignored.
- Compare: when the delay-line output is valid, the block checks `dut_y` against the stored expected value.
  - With LAT=0, the check is combinational against the current ~stim_a with the current `stim_valid`.
  - On a mismatch, `err_count` increments and saturates at 255.
  - If this is the first mismatch, `first_err_idx` and `first_err_got` are captured and not overwritten afterwards.
- Comparisons continue in DRAIN. No comparisons happen in IDLE or DONE.
- Width rule: expected = bitwise NOT of `stim_a`, truncated to WIDTH. For WIDTH=2: 0→3, 1→2, 2→1, 3→0.

## Timing
- A vector accepted at edge n is compared at edge n+LAT, sampling `dut_y` in the cycle before edge n+LAT (same cycle when LAT=0).
- `done` rises on the edge after the last comparison. `pass` is valid in the same cycle as `done`.
- Back-to-back `stim_valid` is supported, at 1 vector per cycle and with no bubbles required.
- `rst` asserted mid-run aborts the run in the next cycle: all outputs return to their reset values and pending pipeline entries are discarded.
- `start` and `rst` high together: `rst` wins.
- Total run length with continuous `stim_valid` is NUM_VECTORS + LAT + 1 cycles from the first accept to `done`.

## Test plan
- LAT=0, NUM_VECTORS=10, sequence 0,0,0,0,1,1,1,2,2,3, DUT is a correct NOT → `done` high, `pass`=1, `err_count`=0, `vec_count`=10.
- LAT=0, same sequence with `dut_y` forced to 2 on vector index 7 (expected 1) → `err_count`=1, `first_err_idx`=7, `first_err_got`=2, `pass`=0.
- LAT=2, correct DUT delayed by 2 registers, continuous `stim_valid` → no errors. `done` arrives 13 cycles after the first accept.
- LAT=1, `dut_y` stuck at 0 for 10 vectors → `err_count`=9 (only the A=3 vector matches), `first_err_idx`=0, `first_err_got`=0.
- `rst` pulsed after 4 accepted vectors, then `start` issued → counters restart at 0 and a clean run ends with `vec_count`=10 and `pass`=1.
- `start` pulsed during RUN and `stim_valid` pulsed during DONE → no state change and no counter change.
